// File: rtl/tristate_bus_sched.sv
// tristate_bus_sched: round-robin owner scheduler for a bank of tri-state bus buffers.
// Grants one source at a time, holds its buffer enabled for HOLD cycles with data
// captured at grant, then keeps every buffer disabled for TURNAROUND cycles.
module tristate_bus_sched #(
    parameter int unsigned N_SRC      = 4,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned HOLD       = 2,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         req,
    input  logic [N_SRC*WIDTH-1:0]   data_in,
    output logic [N_SRC-1:0]         buf_en,
    output logic [N_SRC*WIDTH-1:0]   buf_a,
    output logic [N_SRC-1:0]         ack,
    output logic                     busy
);

    localparam int unsigned PTR_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned CNT_MAX = (HOLD > TURNAROUND) ? HOLD : TURNAROUND;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [PTR_W-1:0]         r_last;
    logic [PTR_W-1:0]         w_last_nxt;
    logic [N_SRC-1:0]         r_buf_en;
    logic [N_SRC-1:0]         w_buf_en_nxt;
    logic [N_SRC*WIDTH-1:0]   r_buf_a;
    logic [N_SRC*WIDTH-1:0]   w_buf_a_nxt;
    logic [N_SRC-1:0]         r_ack;
    logic [N_SRC-1:0]         w_ack_nxt;
    logic                     r_busy;
    logic                     w_busy_nxt;

    logic                     w_found;
    logic [PTR_W-1:0]         w_winner;

    // Round-robin search: first requesting source after the last owner, wrapping.
    always_comb begin
        int unsigned idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx = (32'(r_last) + k) % N_SRC;
            if (!w_found && req[PTR_W'(idx)]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(idx);
            end
        end
    end

    // Next-state and next-output logic for the IDLE -> DRIVE -> TURN cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_last_nxt   = r_last;
        w_buf_en_nxt = r_buf_en;
        w_buf_a_nxt  = r_buf_a;
        w_ack_nxt    = '0;
        w_busy_nxt   = r_busy;

        case (r_state)
            S_IDLE: begin
                w_buf_en_nxt = '0;
                w_busy_nxt   = 1'b0;
                if (w_found) begin
                    w_buf_en_nxt = N_SRC'(1) << w_winner;
                    for (int unsigned i = 0; i < N_SRC; i++) begin
                        if (w_winner == PTR_W'(i)) begin
                            w_buf_a_nxt[i*WIDTH +: WIDTH] = data_in[i*WIDTH +: WIDTH];
                        end
                    end
                    w_last_nxt  = w_winner;
                    w_cnt_nxt   = CNT_W'(HOLD - 1);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_DRIVE;
                end
            end

            S_DRIVE: begin
                if (r_cnt == '0) begin
                    w_buf_en_nxt = '0;
                    w_ack_nxt    = N_SRC'(1) << r_last;
                    w_cnt_nxt    = CNT_W'(TURNAROUND - 1);
                    w_state_nxt  = S_TURN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_TURN: begin
                w_buf_en_nxt = '0;
                if (r_cnt == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_buf_en_nxt = '0;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    // State register; reset points the arbiter so source 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_last  <= PTR_W'(N_SRC - 1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Registered bus-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_en <= '0;
            r_buf_a  <= '0;
            r_ack    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_buf_en <= w_buf_en_nxt;
            r_buf_a  <= w_buf_a_nxt;
            r_ack    <= w_ack_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign buf_en = r_buf_en;
    assign buf_a  = r_buf_a;
    assign ack    = r_ack;
    assign busy   = r_busy;

endmodule

// File: tb/tb_tristate_bus_sched.sv
// Bench for tristate_bus_sched: a per-cycle reference model pushes expected outputs
// into a scoreboard as each stimulus cycle is driven; they are popped and compared
// at the following falling edge, alongside directed checks of grant order and timing.
module tb_tristate_bus_sched;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int HOLD = 2;
    localparam int TURN = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [N-1:0]  req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]  buf_en;
    logic [N*W-1:0] buf_a;
    logic [N-1:0]  ack;
    logic          busy;

    logic          reset6;
    logic [N-1:0]  req6;
    logic [N*W-1:0] data6;
    logic [N-1:0]  buf_en6;
    logic [N*W-1:0] buf_a6;
    logic [N-1:0]  ack6;
    logic          busy6;

    tristate_bus_sched #(.N_SRC(N), .WIDTH(W), .HOLD(HOLD), .TURNAROUND(TURN)) dut (
        .clk(clk), .reset(reset), .req(req), .data_in(data_in),
        .buf_en(buf_en), .buf_a(buf_a), .ack(ack), .busy(busy)
    );

    tristate_bus_sched #(.N_SRC(N), .WIDTH(W), .HOLD(1), .TURNAROUND(3)) dut6 (
        .clk(clk), .reset(reset6), .req(req6), .data_in(data6),
        .buf_en(buf_en6), .buf_a(buf_a6), .ack(ack6), .busy(busy6)
    );

    typedef struct packed {
        logic [N-1:0]   en;
        logic [N*W-1:0] a;
        logic [N-1:0]   ack;
        logic           busy;
    } exp_t;

    exp_t sb_q[$];
    int   order_q[$];

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;

    // Reference model: age counts edges since the grant; HOLD+TURN means idle.
    int          m_age   = HOLD + TURN;
    int          m_last  = N - 1;
    int          m_owner = 0;
    logic [N*W-1:0] m_a  = '0;

    logic [N-1:0] prev_en = '0;
    int           low_run = 100;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   found;
        int   idx;
        e = '0;
        if (reset) begin
            m_age  = HOLD + TURN;
            m_last = N - 1;
            m_a    = '0;
        end else begin
            if (m_age < HOLD + TURN) begin
                m_age++;
            end else if (req != '0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (!found && req[idx]) begin
                        found   = 1;
                        m_owner = idx;
                    end
                end
                m_last = m_owner;
                m_a[m_owner*W +: W] = data_in[m_owner*W +: W];
                m_age  = 0;
            end
            e.en   = (m_age < HOLD) ? N'(1 << m_owner) : '0;
            e.ack  = (m_age == HOLD) ? N'(1 << m_owner) : '0;
            e.busy = (m_age < HOLD + TURN);
            e.a    = m_a;
        end
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        int   who;
        model_step();
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check("buf_en", 32'(buf_en), 32'(e.en));
        check("buf_a",  32'(buf_a),  32'(e.a));
        check("ack",    32'(ack),    32'(e.ack));
        check("busy",   32'(busy),   32'(e.busy));
        check("onehot0", 32'($onehot0(buf_en)), 32'd1);
        check("onehot0_6", 32'($onehot0(buf_en6)), 32'd1);
        if (reset) begin
            low_run = 100;
        end else if (buf_en != '0 && prev_en == '0) begin
            who = 0;
            for (int i = 0; i < N; i++) if (buf_en[i]) who = i;
            order_q.push_back(who);
            if (low_run < 100) check("gap", 32'(low_run >= 2), 32'd1);
            low_run = 0;
        end else if (buf_en == '0 && low_run < 100) begin
            low_run++;
        end else if (buf_en == '0 && prev_en != '0) begin
            low_run = 1;
        end
        prev_en = buf_en;
    endtask

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        reset   = 1'b1;
        req     = 4'b1111;
        data_in = 16'h0000;
        reset6  = 1'b1;
        req6    = 4'b0000;
        data6   = 16'h0003;

        // Reset with all requests asserted: outputs held at zero.
        cycle();
        cycle();
        check("rst_en", 32'(buf_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single request from source 2.
        reset   = 1'b0;
        req     = 4'b0100;
        data_in = 16'h0A00;
        cycle();
        check("t2_en", 32'(buf_en), 32'b0100);
        check("t2_a", 32'(buf_a[11:8]), 32'b1010);
        req = 4'b0000;
        cycle();
        check("t2_en2", 32'(buf_en), 32'b0100);
        cycle();
        check("t2_ack", 32'(ack), 32'b0100);
        check("t2_off", 32'(buf_en), 32'd0);
        cycle();
        check("t2_ackend", 32'(ack), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);

        // All sources requesting continuously from a fresh pointer.
        reset = 1'b1;
        cycle();
        cycle();
        reset   = 1'b0;
        req     = 4'b1111;
        data_in = 16'h4321;
        order_q.delete();
        repeat (20) cycle();
        check("t3_ngrants", 32'(order_q.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < order_q.size()) check("t3_order", 32'(order_q[i]), 32'(exp_order[i]));
        end
        check("t3_a", 32'(buf_a), 32'h4321);

        // Data change and req drop during a grant are ignored.
        req   = 4'b0000;
        reset = 1'b1;
        cycle();
        cycle();
        reset   = 1'b0;
        req     = 4'b0010;
        data_in = 16'h00F0;
        cycle();
        check("t4_en", 32'(buf_en), 32'b0010);
        check("t4_a", 32'(buf_a[7:4]), 32'hF);
        data_in = 16'h0050;
        req     = 4'b0000;
        cycle();
        check("t4_en_hold", 32'(buf_en[1]), 32'd1);
        check("t4_a_hold", 32'(buf_a[7:4]), 32'hF);
        cycle();
        check("t4_ack", 32'(ack), 32'b0010);
        cycle();
        cycle();

        // Reset during source 3's first drive cycle.
        req     = 4'b1000;
        data_in = 16'h7000;
        cycle();
        check("t5_en", 32'(buf_en), 32'b1000);
        reset = 1'b1;
        req   = 4'b0000;
        cycle();
        check("t5_rst_en", 32'(buf_en), 32'd0);
        check("t5_rst_ack", 32'(ack), 32'd0);
        reset = 1'b0;
        req   = 4'b1001;
        cycle();
        check("t5_first", 32'(buf_en), 32'b0001);
        req = 4'b0000;
        repeat (4) cycle();

        // HOLD=1, TURNAROUND=3 instance: one enable cycle in every five.
        reset6 = 1'b0;
        req6   = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            check("t6_en", 32'(buf_en6[0]), 32'((k - 1) % 5 == 0));
            check("t6_ack", 32'(ack6[0]), 32'(k >= 2 && (k - 2) % 5 == 0));
            check("t6_other", 32'(buf_en6[3:1]), 32'd0);
        end
        check("t6_a", 32'(buf_a6[3:0]), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
